// File: rtl/branch_hazard_ctrl.sv
// Branch hazard control for ID-stage branch resolution: stalls, comparator forwarding, redirect/flush, stats.
// Latency: a branch resolves 1+N cycles after id_branch rises (N = 0..2 stall cycles); outputs are combinational.
// Backpressure: stall holds PC and IF/ID while a producer is still unable to forward; dropping id_branch aborts.
module branch_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_branch,
    input  logic        id_branch_type,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_regwrite,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        cmp_branch,
    input  logic        clr_stats,
    output logic        cmp_branch_type,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall,
    output logic        pc_sel,
    output logic        flush_ifid,
    output logic [15:0] branch_cnt,
    output logic [15:0] taken_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] STALL   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;

    logic [1:0] state, state_nxt;
    logic [1:0] scnt, scnt_nxt;
    logic       resolve, stall_int;
    logic [1:0] need_a, need_b, need_n;
    logic [1:0] fsel_a, fsel_b;

    // A producer only counts when it writes a non-zero register that the branch reads.
    function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    // Stall cycles an operand needs before its value is reachable by the comparator.
    function automatic logic [1:0] need_of(input logic [4:0] rs);
        if (hit(ex_regwrite, ex_rd, rs))
            return ex_memread ? 2'd2 : 2'd1;
        else if (hit(mem_regwrite, mem_rd, rs) && mem_memread)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    // Comparator operand source once nothing is left to wait for.
    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (hit(mem_regwrite, mem_rd, rs) && !mem_memread)
            return 2'b01;
        else if (hit(wb_regwrite, wb_rd, rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Hazard depth and forwarding selects for the current ID-stage branch.
    always_comb begin
        need_a = need_of(id_rs1);
        need_b = need_of(id_rs2);
        need_n = (need_a > need_b) ? need_a : need_b;
        fsel_a = fwd_of(id_rs1);
        fsel_b = fwd_of(id_rs2);
    end

    // Sequencing: decide whether this cycle stalls or resolves, and where to go next.
    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        resolve   = 1'b0;
        stall_int = 1'b0;
        case (state)
            IDLE: begin
                if (id_branch) begin
                    if (need_n == 2'd0) begin
                        resolve = 1'b1;
                    end else begin
                        stall_int = 1'b1;
                        scnt_nxt  = need_n - 2'd1;
                        state_nxt = (need_n == 2'd2) ? STALL : RESOLVE;
                    end
                end
            end
            STALL: begin
                if (id_branch) begin
                    stall_int = 1'b1;
                    scnt_nxt  = scnt - 2'd1;
                    state_nxt = RESOLVE;
                end else begin
                    scnt_nxt  = 2'd0;
                    state_nxt = IDLE;
                end
            end
            RESOLVE: begin
                resolve   = id_branch;
                scnt_nxt  = 2'd0;
                state_nxt = IDLE;
            end
            default: begin
                scnt_nxt  = 2'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are held quiet while reset is asserted, even if a branch sits in ID.
    always_comb begin
        cmp_branch_type = id_branch_type;
        stall           = rst_n && stall_int;
        pc_sel          = rst_n && resolve && cmp_branch;
        flush_ifid      = rst_n && resolve && cmp_branch;
        fwd_a           = (rst_n && resolve) ? fsel_a : 2'b00;
        fwd_b           = (rst_n && resolve) ? fsel_b : 2'b00;
    end

    // State and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            scnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
        end
    end

    // Saturating resolution statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt <= 16'd0;
            taken_cnt  <= 16'd0;
        end else if (clr_stats) begin
            branch_cnt <= 16'd0;
            taken_cnt  <= 16'd0;
        end else if (resolve) begin
            if (branch_cnt != 16'hFFFF)
                branch_cnt <= branch_cnt + 16'd1;
            if (cmp_branch && (taken_cnt != 16'hFFFF))
                taken_cnt <= taken_cnt + 16'd1;
        end
    end

endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge), rst_n.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_branch  in  1  ID stage holds a conditional branch (beq/bne).
REQ-005 id_branch_type  in  1  1=beq, 0=bne.
REQ-006 id_rs1, id_rs2  in  5 each  branch source registers.
REQ-007 ex_regwrite, ex_memread  in  1 each; ex_rd  in  5  producer in EX.
REQ-008 mem_regwrite, mem_memread  in  1 each; mem_rd  in  5  producer in MEM.
REQ-009 wb_regwrite  in  1; wb_rd  in  5  producer in WB.
REQ-010 cmp_branch  in  1  comparator decision (1 = condition true).
REQ-011 clr_stats  in  1  synchronous clear of statistics counters.
REQ-012 cmp_branch_type  out  1  drives comparator BranchType.
REQ-013 fwd_a, fwd_b  out  2 each  comparator operand select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data.
REQ-014 stall  out  1  hold PC and IF/ID, bubble into ID/EX.
REQ-015 pc_sel  out  1  select branch target for next PC.
REQ-016 flush_ifid  out  1  squash IF/ID.
REQ-017 branch_cnt, taken_cnt  out  16 each  resolved / taken branch counts.

Function
REQ-018 FSM states SHALL be IDLE, STALL, RESOLVE; 2-bit stall counter scnt.
REQ-019 A register match SHALL require rd == rs and rd != 0 and the stage's regwrite = 1.
REQ-020 Per operand, need = 2 if EX match with ex_memread=1; else 1 if EX match (ALU); else 1 if MEM match with mem_memread=1; else 0. N = max(need_rs1, need_rs2).
REQ-021 IDLE, id_branch=1, N=0: resolve combinationally in the same cycle (REQ-024); next state IDLE.
REQ-022 IDLE, id_branch=1, N>0: stall=1 combinationally; scnt <= N-1; next state STALL if N=2, RESOLVE if N=1.
REQ-023 STALL: stall=1; next state RESOLVE. If id_branch=0 in STALL or RESOLVE: return to IDLE, no resolution, no count update.
REQ-024 Resolution cycle (IDLE with N=0, or RESOLVE): stall=0; pc_sel=cmp_branch; flush_ifid=cmp_branch; next state IDLE.
REQ-025 fwd_x in resolution cycle: 01 if MEM match with mem_memread=0; else 10 if WB match; else 00. fwd_a/fwd_b SHALL be 00 when not resolving.
REQ-026 cmp_branch_type SHALL equal id_branch_type at all times.
REQ-027 pc_sel, flush_ifid SHALL be 0 outside a resolution cycle; stall SHALL be 0 when id_branch=0.
REQ-028 branch_cnt SHALL increment by 1 per resolution; taken_cnt additionally when cmp_branch=1; both saturate at 16'hFFFF.
REQ-029 clr_stats=1 SHALL zero both counters next edge, overriding a same-cycle increment.
REQ-030 Total branch latency SHALL be 1+N cycles from id_branch assertion; max 3.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, scnt=0, branch_cnt=0, taken_cnt=0, independent of clk.
REQ-032 During reset stall, pc_sel, flush_ifid SHALL be 0 and fwd_a/fwd_b 00; reset mid-STALL aborts the branch with no count.

Verification
REQ-033 beq, rs1=5, rs2=6, no producers, cmp_branch=1 -> same cycle pc_sel=1, flush_ifid=1, stall=0; branch_cnt=1, taken_cnt=1.
REQ-034 bne, rs1=5, ex_rd=5, ex_regwrite=1, ex_memread=0 -> 1 stall cycle, then resolve with fwd_a=01 (producer now in MEM).
REQ-035 beq, rs2=7, ex_rd=7 load -> 2 stall cycles, resolve with fwd_b=10; ex_rd=0 load instead -> no stall.
REQ-036 id_branch drops during STALL -> IDLE next edge, pc_sel never 1, counters unchanged; rst_n=0 mid-STALL -> outputs 0 at once.
REQ-037 branch_cnt=16'hFFFF, resolution -> stays 16'hFFFF; clr_stats with same-cycle resolution -> both counters 0.
